// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Issues one command at a time to an external combinational ALU,
//            holds the operands for SETTLE_CYCLES edges, then queues the
//            sampled result in a first-word-fall-through result FIFO.
// Options  : ALU_SEQ_STATS_EN adds a 16-bit op_count output (pushes counted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [16:0] alu_y,
  input  logic        alu_co,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [16:0] res_y,
  output logic        res_co,
  output logic [2:0]  res_op
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int                c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_full    = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [3:0]        c_settle  = 4'(SETTLE_CYCLES);
  localparam logic [c_ptr_w-1:0] c_ptr_one = {{(c_ptr_w - 1){1'b0}}, 1'b1};
  localparam logic [c_ptr_w:0]  c_cnt_one = {{c_ptr_w{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_settle;
  logic                 r_run;
  logic [20:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_ptr_w:0]     r_count;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  assign w_full    = (r_count == c_full);
  // r_run keeps cmd_ready low through reset and for the edge it releases on.
  assign cmd_ready = r_run && (r_state == IDLE) && !w_full;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_push    = (r_state == DRIVE) && (r_settle == 4'd1) && !w_full;
  assign w_pop     = res_valid && res_ready;

  assign res_valid = (r_count != '0);
  assign {res_y, res_co, res_op} = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = DRIVE;
      DRIVE:   if (r_settle == 4'd1) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand registers only change on acceptance, so the ALU inputs stay put in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      r_settle <= '0;
    end else if (w_accept) begin
      alu_a    <= cmd_a;
      alu_b    <= cmd_b;
      alu_op   <= cmd_op;
      r_settle <= c_settle;
    end else if (r_state == DRIVE) begin
      r_settle <= r_settle - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {alu_y, alu_co, alu_op};
        r_wptr        <= r_wptr + c_ptr_one;
      end
      if (w_pop) r_rptr <= r_rptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_op_count <= '0;
    else if (w_push) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Directed self-checking bench; adder ALU model, SETTLE_CYCLES=2
//            main instance plus a SETTLE_CYCLES=1 instance for throughput.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [16:0] alu_y;
  logic        alu_co;
  logic        res_valid, res_ready;
  logic [16:0] res_y;
  logic        res_co;
  logic [2:0]  res_op;

  logic        cmd1_valid, cmd1_ready;
  logic [15:0] cmd1_a, cmd1_b;
  logic [2:0]  cmd1_op;
  logic [15:0] alu1_a, alu1_b;
  logic [2:0]  alu1_op;
  logic [16:0] alu1_y;
  logic        alu1_co;
  logic        res1_valid, res1_ready;
  logic [16:0] res1_y;
  logic        res1_co;
  logic [2:0]  res1_op;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count, op1_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc [3];

  // Adder ALU model; carry-out is bit 16 of the sum.
  assign alu_y   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_co  = alu_y[16];
  assign alu1_y  = {1'b0, alu1_a} + {1'b0, alu1_b};
  assign alu1_co = alu1_y[16];

  alu_op_sequencer #(.SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_co(alu_co),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_co(res_co), .res_op(res_op)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready),
    .cmd_a(cmd1_a), .cmd_b(cmd1_b), .cmd_op(cmd1_op),
    .alu_a(alu1_a), .alu_b(alu1_b), .alu_op(alu1_op),
    .alu_y(alu1_y), .alu_co(alu1_co),
    .res_valid(res1_valid), .res_ready(res1_ready),
    .res_y(res1_y), .res_co(res1_co), .res_op(res1_op)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a command and return at the negedge following its acceptance edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int n = 0; n < 20 && !cmd_ready; n++) @(negedge clk);
    chk("send_handshake", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    cmd1_valid = 1'b0; cmd1_a = '0; cmd1_b = '0; cmd1_op = '0; res1_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_y",     {15'd0, res_y}, 32'd0);
    chk("rst_alu_a",     {16'd0, alu_a}, 32'd0);
    chk("rst_alu_op",    {29'd0, alu_op}, 32'd0);

    rst_n = 1'b1;
    #1 chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release",  {31'd0, cmd_ready}, 32'd1);
    chk("ready1_after_release", {31'd0, cmd1_ready}, 32'd1);

    // 10 + 5, latency of two edges after acceptance
    cmd_a = 16'd10; cmd_b = 16'd5; cmd_op = 3'b001; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_in_drive", {31'd0, cmd_ready}, 32'd0);
    chk("alu_a_loaded",  {16'd0, alu_a}, 32'd10);
    chk("lat_edge0",     {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge1",     {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2",     {31'd0, res_valid}, 32'd1);
    chk("add_res_y",     {15'd0, res_y}, 32'd15);
    chk("add_res_co",    {31'd0, res_co}, 32'd0);
    chk("add_res_op",    {29'd0, res_op}, 32'd1);
    chk("ready_back",    {31'd0, cmd_ready}, 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pop_empty", {31'd0, res_valid}, 32'd0);

    // 20 + 30 with res_ready already high: popped on the following edge
    cmd_a = 16'd20; cmd_b = 16'd30; cmd_op = 3'b110; cmd_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("r29_valid", {31'd0, res_valid}, 32'd1);
    chk("r29_y",     {15'd0, res_y}, 32'd50);
    chk("r29_op",    {29'd0, res_op}, 32'd6);
    @(negedge clk);
    chk("r29_popped",   {31'd0, res_valid}, 32'd0);
    chk("alu_a_held",   {16'd0, alu_a}, 32'd20);
    res_ready = 1'b0;

    // carry-out boundary: 0xFFFF + 2
    send(16'hFFFF, 16'd2, 3'd3);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("carry_y",  {15'd0, res_y}, 32'h10001);
    chk("carry_co", {31'd0, res_co}, 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Fill the FIFO with res_ready low; a 5th command must wait for a pop
    for (int i = 1; i <= 4; i++) send(16'(i), 16'd100, 3'(i));
    cmd_a = 16'd5; cmd_b = 16'd100; cmd_op = 3'd5; cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("full_head_y",  {15'd0, res_y}, 32'd101);
    chk("full_head_op", {29'd0, res_op}, 32'd1);
    chk("full_no_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("full_still_blocked", {31'd0, cmd_ready}, 32'd0);
    chk("fifth_held_alu_a",   {16'd0, alu_a}, 32'd4);
    chk("head_stable_y",      {15'd0, res_y}, 32'd101);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_pop_y",     {15'd0, res_y}, 32'd102);
    chk("after_pop_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fifth_accepted", {16'd0, alu_a}, 32'd5);
    repeat (2) @(negedge clk);
    for (int k = 2; k <= 5; k++) begin
      chk("drain_valid", {31'd0, res_valid}, 32'd1);
      chk("drain_y",     {15'd0, res_y}, 32'(100 + k));
      chk("drain_op",    {29'd0, res_op}, 32'(k));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    chk("drained", {31'd0, res_valid}, 32'd0);

    // Reset one cycle after acceptance discards the in-flight operation
    send(16'd7, 16'd9, 3'd2);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("discarded", {31'd0, res_valid}, 32'd0);

    // SETTLE_CYCLES=1 instance: back-to-back accepts every 2 cycles
    cmd1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd1_a = 16'(i * 10 + 1); cmd1_b = 16'd2; cmd1_op = 3'(i);
      for (int n = 0; n < 20 && !cmd1_ready; n++) @(negedge clk);
      chk("b2b_handshake", {31'd0, cmd1_ready}, 32'd1);
      acc_cyc[i] = cyc;
      @(negedge clk);
    end
    cmd1_valid = 1'b0;
    @(negedge clk);
    chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", {31'd0, res1_valid}, 32'd1);
      chk("b2b_y",     {15'd0, res1_y}, 32'(i * 10 + 3));
      chk("b2b_op",    {29'd0, res1_op}, 32'(i));
      res1_ready = 1'b1;
      @(negedge clk);
      res1_ready = 1'b0;
    end
    chk("b2b_drained", {31'd0, res1_valid}, 32'd0);

`ifdef ALU_SEQ_STATS_EN
    force dut.r_op_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_op_count;
    send(16'd1, 16'd1, 3'd0);
    send(16'd2, 16'd2, 3'd0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("op_count_wrap", {16'd0, op_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles operands are held on the ALU before the result is sampled (legal 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports cmd_valid  input  1, cmd_ready  output  1, cmd_a  input  16, cmd_b  input  16, cmd_op  input  3: the command channel.
REQ-006 SHALL have ports alu_a  output  16, alu_b  output  16, alu_op  output  3: operands driven to the external combinational ALU.
REQ-007 SHALL have ports alu_y  input  17, alu_co  input  1: the ALU result and carry-out.
REQ-008 SHALL have ports res_valid  output  1, res_ready  input  1, res_y  output  17, res_co  output  1, res_op  output  3: the result channel.

Function
REQ-009 SHALL implement an FSM with states IDLE and DRIVE, one operation in flight at most.
REQ-010 SHALL assert cmd_ready only when the state is IDLE and the FIFO is not full.
REQ-011 SHALL accept a command on a rising edge with cmd_valid and cmd_ready both high: register cmd_a, cmd_b and cmd_op onto alu_a, alu_b and alu_op, load the settle counter with SETTLE_CYCLES, and enter DRIVE.
REQ-012 SHALL hold alu_a, alu_b and alu_op stable from acceptance until the next acceptance, including through IDLE.
REQ-013 SHALL decrement the settle counter on each edge in DRIVE.
REQ-014 SHALL, on the edge where the counter reaches zero (accept edge + SETTLE_CYCLES), push {alu_y, alu_co, alu_op} into the FIFO and return to IDLE.
REQ-015 SHALL implement the FIFO as first-word-fall-through: res_valid is high whenever the FIFO is non-empty, and res_y, res_co and res_op present the head entry.
REQ-016 SHALL pop the FIFO on an edge with res_valid and res_ready both high.
REQ-017 SHALL, on a simultaneous push and pop, keep the occupancy unchanged and preserve order.
REQ-018 SHALL never push into a full FIFO; the REQ-010 gating guarantees a free slot at capture.
REQ-019 SHALL wrap the read and write pointers modulo FIFO_DEPTH and track occupancy 0..FIFO_DEPTH exactly.
REQ-020 SHALL hold res_y, res_co and res_op stable while res_valid is high and res_ready is low.
REQ-021 SHALL have a result latency of SETTLE_CYCLES edges from acceptance to res_valid when the FIFO is empty.
REQ-022 SHALL have a back-to-back throughput of one command per SETTLE_CYCLES+1 cycles.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE, settle counter 0, FIFO empty, res_valid 0, res_y/res_co/res_op 0, alu_a/alu_b/alu_op 0, and cmd_ready 0.
REQ-024 SHALL, on reset during DRIVE, discard the in-flight operation so that it never appears on the result channel.
REQ-025 SHALL raise cmd_ready on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro ALU_SEQ_STATS_EN is defined, add output port op_count (16 bits) that counts FIFO pushes, resets to 0, and wraps from 0xFFFF to 0x0000.
REQ-027 SHALL, without ALU_SEQ_STATS_EN, have neither the op_count port nor its counter, with all other behaviour identical.

Verification
REQ-028 SHALL cover: with an ALU model of Y=A+B, cmd A=10, B=5, op=001 -> res_valid exactly 2 edges after accept, with res_y=15, res_co=0, res_op=001.
REQ-029 SHALL cover: cmd A=20, B=30, op=110 with res_ready=1 -> res_y=50 and res_op=110 popped the following edge; FIFO empty again afterwards.
REQ-030 SHALL cover: res_ready=0 with 5 commands offered -> 4 results stored; cmd_ready stays low after the 4th capture; the 5th command is held; one pop re-enables cmd_ready and the 5th completes in order.
REQ-031 SHALL cover: rst_n pulsed low 1 cycle after accepting A=7, B=9 -> no result emitted, all outputs 0, cmd_ready=1 on the edge after release.
REQ-032 SHALL cover: SETTLE_CYCLES=1 with back-to-back commands -> one accept every 2 cycles and results in issue order.
REQ-033 SHALL cover, with ALU_SEQ_STATS_EN: op_count forced to 0xFFFE, then 2 operations -> op_count reads 0x0000.
